risc32_intc: RTL and testbench
==============================

Name: risc32_intc

Overview:
- Interrupt controller that drives the risc32_core `interrupt` input and completes the `interrupt`/`interrupt_ack` handshake from the requester side.
- Collects NUM_SRC peripheral interrupt sources, latches rising edges as pending, applies a mask, and picks the highest-priority source.
- Presents the winning source ID to the core while the request is held.
- Mask and pending are configured through a small synchronous register port driven by the core's I/O decode.

Parameters:
- NUM_SRC, 8, number of interrupt sources (2..32)
- ID_W, 3, width of `irq_id`; must satisfy 2^ID_W >= NUM_SRC

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- src  input  NUM_SRC  interrupt sources, synchronous to clk, level; rising edge = event
- cfg_we  input  1  config write strobe, single cycle
- cfg_addr  input  1  0 = mask register, 1 = pending clear (write-1-to-clear)
- cfg_wdata  input  NUM_SRC  config write data
- mask  output  NUM_SRC  current enable mask (1 = enabled)
- pending  output  NUM_SRC  current pending bits
- interrupt  output  1  request to core; registered
- interrupt_ack  input  1  acknowledge from core, level
- irq_id  output  ID_W  index of the requested source; stable while `interrupt`=1
- busy  output  1  high in REQ and ACK_WAIT states

Behaviour:
- Reset (sampled on clk edge with `reset`=1): mask=0, pending=0, src_q=0, interrupt=0, irq_id=0, busy=0, state=IDLE. Reset asserted mid-handshake aborts it; outputs reach reset values after that edge. Synchronous reset has priority over every other action.
- Edge detect: src_q <= src every cycle. For each bit i, `src[i]=1 && src_q[i]=0` at edge N sets pending[i] after edge N. A level held high sets pending only once.
- Config writes:
  - cfg_we with cfg_addr=0: mask <= cfg_wdata.
  - cfg_we with cfg_addr=1: pending[i] cleared where cfg_wdata[i]=1.
- Pending set/clear precedence, in one cycle: a new edge set beats both a cfg clear and an ack clear of the same bit.
- Priority: lowest index wins among (pending & mask).
- FSM:
  - IDLE: if |(pending & mask) then irq_id <= winning index, interrupt <= 1, go REQ; else hold.
  - REQ: interrupt=1 and irq_id held even if mask or pending change (no request withdrawal). When interrupt_ack=1 is sampled: pending[irq_id] <= 0 (subject to the edge-set precedence), interrupt <= 0, go ACK_WAIT.
  - ACK_WAIT: interrupt=0. When interrupt_ack=0 is sampled, go IDLE.
  - interrupt_ack=1 observed in IDLE is ignored.
- Latency:
  - src rises, sampled at edge N, source enabled: interrupt=1 after edge N+1.
  - ack sampled at edge M: interrupt=0 after edge M.
  - Minimum gap between consecutive requests: ack deasserted at edge K, next interrupt=1 after edge K+1.
- irq_id retains its last value outside REQ.
- Width rules: irq_id is zero-extended when NUM_SRC < 2^ID_W. Bits at or above NUM_SRC do not exist.

Test Plan:
- Reset then idle: after reset, mask=0, pending=0, interrupt=0, busy=0; pulse src=8'h01 with mask=0 -> pending=8'h01, interrupt stays 0.
- Single interrupt: write mask=8'hFF, pulse src[3] at edge N -> pending=8'h08 after N, interrupt=1 and irq_id=3 after N+1. Ack high 2 cycles later -> interrupt=0 and pending=0 the next edge, busy=1 until ack drops, then busy=0.
- Priority and serialization: mask=8'hFF, src=8'h84 rising in one cycle -> first request irq_id=2. After ack/deack, second request irq_id=7. Pending=8'h80 between the two, 8'h00 at end.
- No withdrawal: during REQ with irq_id=5, write mask=0 -> interrupt stays 1 and irq_id stays 5 until ack.
- Simultaneous set/clear: in the ack cycle for irq_id=1, src[1] rises again -> pending[1] stays 1 and a new request for id 1 follows after ack drops.
- Held level, W1C and reset mid-handshake:
  - src[0] held high 10 cycles -> exactly one pending set.
  - cfg write addr=1 data=8'h01 -> pending[0]=0.
  - reset asserted in REQ -> interrupt=0, state IDLE, pending=0 after one edge.

Source files
------------

// File: rtl/risc32_intc.sv
// risc32_intc: interrupt controller feeding the risc32_core interrupt input.
//
// Latches rising edges on NUM_SRC level sources into pending bits, gates them
// with an enable mask and raises a single registered request carrying the
// lowest-index enabled pending source. The request is held, with its ID
// frozen, until the core acknowledges; the core must then drop its ack before
// the next request can be raised.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   src           interrupt sources (level, rising edge = event)
//   cfg_we        config write strobe
//   cfg_addr      0 = mask register, 1 = pending write-1-to-clear
//   cfg_wdata     config write data
//   mask          current enable mask
//   pending       current pending bits
//   interrupt     registered request to the core
//   interrupt_ack acknowledge from the core (level)
//   irq_id        index of the requested source
//   busy          high while a request or ack handshake is in progress

module risc32_intc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic               cfg_we,
    input  logic               cfg_addr,
    input  logic [NUM_SRC-1:0] cfg_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic [ID_W-1:0]    irq_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StAckWait = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               interrupt_q;
    logic [ID_W-1:0]    irq_id_q;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] active;
    logic [ID_W-1:0]    win_id;
    logic               ack_take;

    assign rise     = src & ~src_q;
    assign active   = pending_q & mask_q;
    assign ack_take = (state_q == StReq) && interrupt_ack;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (cfg_we && !cfg_addr) begin
            mask_d = cfg_wdata;
        end
    end

    // Clears first, then new edges OR'd in so a same-cycle edge always survives.
    always_comb begin
        pending_d = pending_q;
        if (cfg_we && cfg_addr) begin
            pending_d = pending_d & ~cfg_wdata;
        end
        if (ack_take) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (irq_id_q == ID_W'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= src;
            mask_q    <= mask_d;
            pending_q <= pending_d;
        end
    end

    // Request FSM; interrupt and irq_id are registered outputs of this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            interrupt_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|active) begin
                        irq_id_q    <= win_id;
                        interrupt_q <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    // No withdrawal: mask/pending changes do not affect a live request.
                    if (interrupt_ack) begin
                        interrupt_q <= 1'b0;
                        state_q     <= StAckWait;
                    end
                end
                StAckWait: begin
                    if (!interrupt_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    interrupt_q <= 1'b0;
                end
            endcase
        end
    end

    assign mask      = mask_q;
    assign pending   = pending_q;
    assign interrupt = interrupt_q;
    assign irq_id    = irq_id_q;
    assign busy      = (state_q == StReq) || (state_q == StAckWait);

endmodule

// File: tb/tb_risc32_intc.sv
module tb_risc32_intc;

    logic       clk;
    logic       reset;
    logic [7:0] src;
    logic       cfg_we;
    logic       cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       interrupt;
    logic       interrupt_ack;
    logic [2:0] irq_id;
    logic       busy;

    int n_cmp;
    int n_err;

    risc32_intc #(
        .NUM_SRC(8),
        .ID_W   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src          (src),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .mask         (mask),
        .pending      (pending),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .irq_id       (irq_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic addr, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (mask !== 8'h00) begin n_err++; $display("FAIL reset_mask: got %h want 00", mask); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %h want 00", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
        src = 8'h01;
        tick();
        src = 8'h00;
        n_cmp++; if (pending !== 8'h01) begin n_err++; $display("FAIL idle_pend: got %h want 01", pending); end
        tick();
        tick();
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL idle_masked_irq: got %b want 0", interrupt); end
        // Ack while idle must be ignored
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        n_cmp++; if (pending !== 8'h01) begin n_err++; $display("FAIL idle_ack_ignored: got %h want 01", pending); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_ack_busy: got %b want 0", busy); end
        cfg_write(1'b1, 8'hFF);
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL idle_w1c_all: got %h want 00", pending); end
    endtask

    task automatic test_single();
        cfg_write(1'b0, 8'hFF);
        n_cmp++; if (mask !== 8'hFF) begin n_err++; $display("FAIL single_mask: got %h want FF", mask); end
        src = 8'h08;
        tick(); // edge N
        src = 8'h00;
        n_cmp++; if (pending !== 8'h08) begin n_err++; $display("FAIL single_pend_N: got %h want 08", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_irq_N: got %b want 0", interrupt); end
        tick(); // edge N+1
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL single_irq_N1: got %b want 1", interrupt); end
        n_cmp++; if (irq_id !== 3'd3) begin n_err++; $display("FAIL single_id: got %0d want 3", irq_id); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_req: got %b want 1", busy); end
        tick();
        tick();
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL single_hold: got %b want 1", interrupt); end
        interrupt_ack = 1'b1;
        tick(); // edge M
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_ack_irq: got %b want 0", interrupt); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL single_ack_pend: got %h want 00", pending); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_ackw: got %b want 1", busy); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_ackw2: got %b want 1", busy); end
        interrupt_ack = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
        tick();
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL single_no_rereq: got %b want 0", interrupt); end
    endtask

    task automatic test_priority();
        src = 8'h84;
        tick();
        src = 8'h00;
        n_cmp++; if (pending !== 8'h84) begin n_err++; $display("FAIL prio_pend: got %h want 84", pending); end
        tick();
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL prio_irq1: got %b want 1", interrupt); end
        n_cmp++; if (irq_id !== 3'd2) begin n_err++; $display("FAIL prio_id1: got %0d want 2", irq_id); end
        interrupt_ack = 1'b1;
        tick();
        n_cmp++; if (pending !== 8'h80) begin n_err++; $display("FAIL prio_pend_mid: got %h want 80", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL prio_ack_irq: got %b want 0", interrupt); end
        interrupt_ack = 1'b0;
        tick(); // edge K
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL prio_gap: got %b want 0", interrupt); end
        tick(); // edge K+1
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL prio_irq2: got %b want 1", interrupt); end
        n_cmp++; if (irq_id !== 3'd7) begin n_err++; $display("FAIL prio_id2: got %0d want 7", irq_id); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL prio_pend_end: got %h want 00", pending); end
        tick();
        n_cmp++; if (irq_id !== 3'd7) begin n_err++; $display("FAIL prio_id_retain: got %0d want 7", irq_id); end
    endtask

    task automatic test_no_withdraw();
        src = 8'h20;
        tick();
        src = 8'h00;
        tick();
        n_cmp++; if (irq_id !== 3'd5) begin n_err++; $display("FAIL nowd_id: got %0d want 5", irq_id); end
        cfg_write(1'b0, 8'h00);
        n_cmp++; if (mask !== 8'h00) begin n_err++; $display("FAIL nowd_mask: got %h want 00", mask); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL nowd_irq: got %b want 1", interrupt); end
        tick();
        n_cmp++; if (irq_id !== 3'd5) begin n_err++; $display("FAIL nowd_id_hold: got %0d want 5", irq_id); end
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL nowd_irq_hold: got %b want 1", interrupt); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL nowd_ack: got %b want 0", interrupt); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL nowd_pend: got %h want 00", pending); end
        tick();
        cfg_write(1'b0, 8'hFF);
    endtask

    task automatic test_set_clear();
        src = 8'h02;
        tick();
        src = 8'h00;
        tick();
        n_cmp++; if (irq_id !== 3'd1) begin n_err++; $display("FAIL sc_id: got %0d want 1", irq_id); end
        // New edge on src[1] in the same cycle the ack clears pending[1]
        src = 8'h02;
        interrupt_ack = 1'b1;
        tick();
        src = 8'h00;
        interrupt_ack = 1'b0;
        n_cmp++; if (pending !== 8'h02) begin n_err++; $display("FAIL sc_pend_kept: got %h want 02", pending); end
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL sc_ack_irq: got %b want 0", interrupt); end
        tick(); // edge K: ack seen low
        tick(); // edge K+1
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL sc_rereq: got %b want 1", interrupt); end
        n_cmp++; if (irq_id !== 3'd1) begin n_err++; $display("FAIL sc_rereq_id: got %0d want 1", irq_id); end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL sc_pend_end: got %h want 00", pending); end
    endtask

    task automatic test_level_w1c_reset();
        cfg_write(1'b0, 8'h00);
        src = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        n_cmp++; if (pending !== 8'h01) begin n_err++; $display("FAIL lvl_pend: got %h want 01", pending); end
        cfg_write(1'b1, 8'h01);
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL w1c_pend: got %h want 00", pending); end
        tick();
        tick();
        // Still high but no new edge: must not re-set
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL lvl_once: got %h want 00", pending); end
        src = 8'h00;
        cfg_write(1'b0, 8'hFF);
        src = 8'h50;
        tick();
        src = 8'h00;
        tick();
        n_cmp++; if (interrupt !== 1'b1) begin n_err++; $display("FAIL rst_pre_irq: got %b want 1", interrupt); end
        n_cmp++; if (irq_id !== 3'd4) begin n_err++; $display("FAIL rst_pre_id: got %0d want 4", irq_id); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", interrupt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (pending !== 8'h00) begin n_err++; $display("FAIL rst_pend: got %h want 00", pending); end
        n_cmp++; if (mask !== 8'h00) begin n_err++; $display("FAIL rst_mask: got %h want 00", mask); end
        n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", irq_id); end
        tick();
        n_cmp++; if (interrupt !== 1'b0) begin n_err++; $display("FAIL rst_after: got %b want 0", interrupt); end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        src           = 8'h00;
        cfg_we        = 1'b0;
        cfg_addr      = 1'b0;
        cfg_wdata     = 8'h00;
        interrupt_ack = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_no_withdraw();
        test_set_clear();
        test_level_w1c_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
